// File: rtl/store_buffer_pkg.sv
// Shared types and sizing for the posted-write store buffer.
// One entry holds a word address, lane-aligned data, byte enables and the issuing PC.
package store_buffer_pkg;

    localparam int SB_DEPTH  = 4;
    localparam int SB_PTR_W  = 2;
    localparam int SB_ADDR_W = 30;
    localparam int SB_DATA_W = 32;
    localparam int SB_BE_W   = 4;
    localparam int SB_PC_W   = 32;

    typedef struct packed {
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
        logic [SB_BE_W-1:0]   be;
        logic [SB_PC_W-1:0]   pc;
    } sb_entry_t;

    // The data memory is 1024 words, so only the word index takes part in a match.
    function automatic logic word_match(input logic [9:0] a_idx, input logic [9:0] b_idx);
        return a_idx == b_idx;
    endfunction

endpackage

// File: rtl/sb_fifo_ctrl.sv
// Circular-queue bookkeeping for the store buffer: head/tail/count, push/pop/stall decisions.
// Zero-latency decisions, state moves on the edge; a full queue still accepts a push when it pops.
module sb_fifo_ctrl
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int PTR_W = SB_PTR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_req,
    input  logic             drain_en,
    output logic             push,
    output logic             pop,
    output logic             stall,
    output logic             empty,
    output logic [PTR_W-1:0] head,
    output logic [PTR_W-1:0] tail
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [PTR_W:0] count;
    logic           full;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    // Reset must never let a write escape to memory in the reset cycle.
    assign pop   = !empty && drain_en && !reset;
    assign push  = push_req && (!full || pop);
    assign stall = push_req && full && !pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer in front of the data memory; loads see pending stores merged per byte lane.
// Store accepted in 1 cycle, visible on dm_* the next cycle; cpu_stall holds the CPU while full without a drain.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int PTR_W = SB_PTR_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_we,
    input  logic        cpu_re,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_be,
    input  logic [31:0] cpu_pc,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        drain_en,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_pc,
    input  logic [31:0] dm_rdata,
    output logic        sb_empty
);

    logic             push;
    logic             pop;
    logic             stall;
    logic             empty;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    sb_entry_t        ent_q [DEPTH];
    logic [DEPTH-1:0] vld_q;

    logic             unused_addr_lsb;
    assign unused_addr_lsb = ^cpu_addr[1:0];

    sb_fifo_ctrl #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_ctrl (
        .clk      (clk),
        .reset    (reset),
        .push_req (cpu_we),
        .drain_en (drain_en),
        .push     (push),
        .pop      (pop),
        .stall    (stall),
        .empty    (empty),
        .head     (head),
        .tail     (tail)
    );

    // Clear before set: when full, the slot being popped is the one being refilled.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
        end else begin
            if (pop)  vld_q[head] <= 1'b0;
            if (push) vld_q[tail] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            ent_q[tail] <= '{addr: cpu_addr[31:2], data: cpu_wdata, be: cpu_be, pc: cpu_pc};
        end
    end

    assign dm_we     = pop;
    assign dm_addr   = {ent_q[head].addr, 2'b00};
    assign dm_wdata  = ent_q[head].data;
    assign dm_be     = ent_q[head].be;
    assign dm_pc     = ent_q[head].pc;
    assign cpu_stall = stall;
    assign sb_empty  = empty;

    // Walk oldest to newest so the newest matching store wins each lane.
    logic [PTR_W-1:0] idx;
    always_comb begin
        cpu_rdata = dm_rdata;
        idx       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (vld_q[idx] && word_match(ent_q[idx].addr[9:0], cpu_addr[11:2])) begin
                for (int k = 0; k < 4; k++) begin
                    if (ent_q[idx].be[k]) cpu_rdata[8*k +: 8] = ent_q[idx].data[8*k +: 8];
                end
            end
        end
    end

    a_no_we_re: assert property (@(posedge clk) disable iff (reset) !(cpu_we && cpu_re))
        else $error("store_buffer: cpu_we and cpu_re asserted in the same cycle");

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios plus a random mix checked against an architectural
// byte-memory model (stores take effect at acceptance) and an in-order drain scoreboard.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_we = 1'b0;
    logic        cpu_re = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [3:0]  cpu_be = '0;
    logic [31:0] cpu_pc = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        drain_en = 1'b0;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic [31:0] dm_pc;
    logic [31:0] dm_rdata;
    logic        sb_empty;

    always #5 clk = ~clk;

    store_buffer dut (
        .clk(clk), .reset(reset), .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_be(cpu_be), .cpu_pc(cpu_pc), .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall), .drain_en(drain_en), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_be(dm_be), .dm_pc(dm_pc), .dm_rdata(dm_rdata), .sb_empty(sb_empty)
    );

    // Data memory environment: combinational read, byte-enabled write on the edge.
    logic [31:0] dmem [1024] = '{default: 32'h0};
    assign dm_rdata = dmem[cpu_addr[11:2]];
    always @(posedge clk) begin
        if (dm_we)
            for (int k = 0; k < 4; k++)
                if (dm_be[k]) dmem[dm_addr[11:2]][8*k +: 8] <= dm_wdata[8*k +: 8];
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] pc;
    } st_t;

    st_t         q[$];
    logic [31:0] ref_mem [1024];
    int          chk_cnt = 0;
    int          pass_cnt = 0;

    task automatic drive_idle();
        cpu_we = 1'b0;
        cpu_re = 1'b0;
    endtask

    task automatic drive_store(input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] be, input logic [31:0] pc);
        cpu_we = 1'b1; cpu_re = 1'b0;
        cpu_addr = a; cpu_wdata = d; cpu_be = be; cpu_pc = pc;
    endtask

    task automatic drive_load(input logic [31:0] a);
        cpu_we = 1'b0; cpu_re = 1'b1; cpu_addr = a;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_idle();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            chk_cnt++; if (sb_empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", sb_empty); else pass_cnt++;
            chk_cnt++; if (dm_we !== 1'b0) $display("FAIL reset_dm_we: got %b want 0", dm_we); else pass_cnt++;
            chk_cnt++; if (cpu_stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", cpu_stall); else pass_cnt++;
        end
    endtask

    task automatic test_single_store();
        @(negedge clk);
        drive_store(32'h10, 32'h1234_5678, 4'b1111, 32'h3000);
        drain_en = 1'b1;
        #1;
        chk_cnt++; if (cpu_stall !== 1'b0) $display("FAIL single_stall: got %b want 0", cpu_stall); else pass_cnt++;
        chk_cnt++; if (dm_we !== 1'b0) $display("FAIL single_same_cycle_we: got %b want 0", dm_we); else pass_cnt++;
        @(negedge clk);
        drive_idle();
        #1;
        chk_cnt++;
        if ({dm_we, dm_addr, dm_wdata, dm_be, dm_pc} !== {1'b1, 32'h10, 32'h1234_5678, 4'hF, 32'h3000})
            $display("FAIL single_drain: got we=%b a=%h d=%h be=%h pc=%h want we=1 a=10 d=12345678 be=f pc=3000",
                     dm_we, dm_addr, dm_wdata, dm_be, dm_pc);
        else pass_cnt++;
        @(negedge clk); #1;
        chk_cnt++; if ({sb_empty, dm_we} !== 2'b10) $display("FAIL single_after: got empty=%b we=%b want 1,0", sb_empty, dm_we); else pass_cnt++;
    endtask

    task automatic test_full_stall();
        drain_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive_store(32'h40 + 32'(4*i), 32'hC0DE_0000 + 32'(i), 4'b1111, 32'h4000 + 32'(4*i));
            #1;
            chk_cnt++;
            if (cpu_stall !== (i == 4)) $display("FAIL full_stall_%0d: got %b want %b", i, cpu_stall, (i == 4));
            else pass_cnt++;
        end
        @(negedge clk);
        drain_en = 1'b1;
        #1;
        chk_cnt++;
        if ({cpu_stall, dm_we, dm_addr} !== {1'b0, 1'b1, 32'h40})
            $display("FAIL full_pop_push: got stall=%b we=%b a=%h want 0,1,40", cpu_stall, dm_we, dm_addr);
        else pass_cnt++;
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            drive_idle();
            #1;
            chk_cnt++;
            if ({dm_we, dm_addr, dm_pc} !== {1'b1, 32'h40 + 32'(4*j), 32'h4000 + 32'(4*j)})
                $display("FAIL full_drain_%0d: got we=%b a=%h pc=%h want 1 %h %h", j, dm_we, dm_addr, dm_pc,
                         32'h40 + 32'(4*j), 32'h4000 + 32'(4*j));
            else pass_cnt++;
        end
        @(negedge clk); #1;
        chk_cnt++; if (sb_empty !== 1'b1) $display("FAIL full_empty_after: got %b want 1", sb_empty); else pass_cnt++;
    endtask

    task automatic test_merge();
        drain_en = 1'b0;
        @(negedge clk); drive_store(32'h20, 32'hAABB_CCDD, 4'b1111, 32'h5000);
        @(negedge clk); drive_store(32'h20, 32'h0000_0011, 4'b0001, 32'h5004);
        @(negedge clk); drive_load(32'h20); #1;
        chk_cnt++; if (cpu_rdata !== 32'hAABB_CC11) $display("FAIL merge_lw: got %h want aabbcc11", cpu_rdata); else pass_cnt++;
        @(negedge clk); drive_load(32'h1020); #1;
        chk_cnt++; if (cpu_rdata !== 32'hAABB_CC11) $display("FAIL merge_alias: got %h want aabbcc11", cpu_rdata); else pass_cnt++;
        @(negedge clk); drive_load(32'h24); #1;
        chk_cnt++; if (cpu_rdata !== 32'h0) $display("FAIL merge_other_word: got %h want 0", cpu_rdata); else pass_cnt++;
        drive_idle();
        drain_en = 1'b1;
        for (int i = 0; i < 10 && !sb_empty; i++) @(negedge clk);
        @(negedge clk); drive_load(32'h20); #1;
        chk_cnt++;
        if ({sb_empty, cpu_rdata} !== {1'b1, 32'hAABB_CC11})
            $display("FAIL merge_in_memory: got empty=%b d=%h want 1 aabbcc11", sb_empty, cpu_rdata);
        else pass_cnt++;
        drive_idle();
    endtask

    task automatic test_reset_mid_drain();
        drain_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive_store(32'h80 + 32'(4*i), 32'hDEAD_BEE0 + 32'(i), 4'b1111, 32'h6000);
        end
        @(negedge clk);
        drive_idle();
        drain_en = 1'b1;
        reset = 1'b1;
        #1;
        chk_cnt++; if (dm_we !== 1'b0) $display("FAIL rstmid_we_in_reset: got %b want 0", dm_we); else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk_cnt++;
            if ({dm_we, sb_empty} !== 2'b01) $display("FAIL rstmid_after_%0d: got we=%b empty=%b want 0,1", i, dm_we, sb_empty);
            else pass_cnt++;
            @(negedge clk);
        end
        drive_load(32'h80); #1;
        chk_cnt++; if (cpu_rdata !== 32'h0) $display("FAIL rstmid_lw: got %h want 0", cpu_rdata); else pass_cnt++;
        drive_idle();
    endtask

    task automatic test_random();
        bit          hold = 0;
        bit          pop_e;
        bit          stall_e;
        int          bad = 0;
        int          r;
        int          lane;
        logic [9:0]  w;
        logic [31:0] up;
        logic [1:0]  off;
        st_t         e;
        for (int i = 0; i < 1024; i++) ref_mem[i] = dmem[i];
        q.delete();
        for (int n = 0; n < 2300; n++) begin
            @(negedge clk);
            if (n >= 2000 && !hold && q.size() == 0) break;
            if (!hold) begin
                drive_idle();
                if (n < 2000) begin
                    r  = $urandom_range(0, 9);
                    w  = 10'($urandom_range(0, 15));
                    up = $urandom;
                    if (r < 4) begin
                        lane = $urandom_range(0, 3);
                        case ($urandom_range(0, 2))
                            0:       begin cpu_be = 4'b1111; off = 2'd0; end
                            1:       begin cpu_be = lane[1] ? 4'b1100 : 4'b0011; off = lane[1] ? 2'd2 : 2'd0; end
                            default: begin cpu_be = 4'b0001 << lane; off = 2'(lane); end
                        endcase
                        cpu_we = 1'b1;
                        cpu_addr = {up[19:0], w, off};
                        cpu_wdata = $urandom;
                        cpu_pc = $urandom;
                    end else if (r < 7) begin
                        drive_load({up[19:0], w, 2'b00});
                    end
                end
            end
            drain_en = (n >= 2000) ? 1'b1 : ($urandom_range(0, 2) != 0);
            #1;
            pop_e = (q.size() > 0) && drain_en;
            chk_cnt++; if (dm_we !== pop_e) $display("FAIL rand_dm_we n=%0d: got %b want %b", n, dm_we, pop_e); else pass_cnt++;
            chk_cnt++; if (sb_empty !== (q.size() == 0)) $display("FAIL rand_empty n=%0d: got %b want %b", n, sb_empty, q.size() == 0); else pass_cnt++;
            if (pop_e) begin
                chk_cnt++;
                if ({dm_addr, dm_wdata, dm_be, dm_pc} !== {q[0].addr[31:2], 2'b00, q[0].data, q[0].be, q[0].pc})
                    $display("FAIL rand_head n=%0d: got a=%h d=%h be=%h pc=%h want a=%h d=%h be=%h pc=%h", n,
                             dm_addr, dm_wdata, dm_be, dm_pc, {q[0].addr[31:2], 2'b00}, q[0].data, q[0].be, q[0].pc);
                else pass_cnt++;
            end
            stall_e = (q.size() == 4) && !pop_e;
            if (cpu_we) begin
                chk_cnt++; if (cpu_stall !== stall_e) $display("FAIL rand_stall n=%0d: got %b want %b", n, cpu_stall, stall_e); else pass_cnt++;
            end
            if (cpu_re) begin
                chk_cnt++;
                if (cpu_rdata !== ref_mem[cpu_addr[11:2]])
                    $display("FAIL rand_load n=%0d addr=%h: got %h want %h", n, cpu_addr, cpu_rdata, ref_mem[cpu_addr[11:2]]);
                else pass_cnt++;
            end
            if (pop_e) void'(q.pop_front());
            if (cpu_we && !stall_e) begin
                e.addr = cpu_addr; e.data = cpu_wdata; e.be = cpu_be; e.pc = cpu_pc;
                q.push_back(e);
                for (int k = 0; k < 4; k++)
                    if (cpu_be[k]) ref_mem[cpu_addr[11:2]][8*k +: 8] = cpu_wdata[8*k +: 8];
                hold = 0;
            end else begin
                hold = cpu_we && stall_e;
            end
        end
        drive_idle();
        @(negedge clk); #1;
        chk_cnt++;
        if ({q.size() == 0, sb_empty} !== 2'b11) $display("FAIL rand_final_empty: got model=%0d empty=%b want 0,1", q.size(), sb_empty);
        else pass_cnt++;
        for (int i = 0; i < 1024; i++) if (dmem[i] !== ref_mem[i]) bad++;
        chk_cnt++; if (bad != 0) $display("FAIL rand_memory: got %0d differing words want 0", bad); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_store();
        test_full_stall();
        test_merge();
        test_reset_mid_drain();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1, "watchdog");
    end

endmodule
